// File: rtl/voice_allocator.sv
// voice_allocator
//   Assigns incoming note events to a pool of envelope voices. A note-on
//   event goes to one of three places, tried in this order:
//     1. retrigger a gated voice that already plays the same note
//     2. start the lowest-index free voice
//     3. steal the voice at a round-robin steal pointer
//   A note-off event ungates every gated voice that plays that note.
//   The block also divides clk down to produce the envelope update strobe.
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   note_valid   a note event is present on the inputs
//   note_ready   the allocator can accept an event (high in S_IDLE)
//   note_on      1 = note-on, 0 = note-off
//   note_num     note number of the event
//   note_vel     envelope targets: [31:16] attack level, [15:0] decay level
//   voice_avail  per-voice one-cycle pulse: that voice finished its release
//   voice_en     per-voice gate to the envelope stage
//   voice_vel    per-voice velocity word; voice i is at [32i+31:32i]
//   voice_note   per-voice note number
//   voice_busy   voice is allocated (gated or still releasing)
//   env_tick     one-cycle envelope update strobe every TICK_DIV cycles
//   voice_steal  one-cycle pulse when a busy voice was reassigned
module voice_allocator #(
  parameter int NUM_VOICES = 8,
  parameter int NOTE_BITS  = 7,
  parameter int TICK_DIV   = 2048
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            note_valid,
  output logic                            note_ready,
  input  logic                            note_on,
  input  logic [NOTE_BITS-1:0]            note_num,
  input  logic [31:0]                     note_vel,
  input  logic [NUM_VOICES-1:0]           voice_avail,
  output logic [NUM_VOICES-1:0]           voice_en,
  output logic [32*NUM_VOICES-1:0]        voice_vel,
  output logic [NOTE_BITS*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]           voice_busy,
  output logic                            env_tick,
  output logic                            voice_steal
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] TICK_PRE  = CW'(TICK_DIV - 2);
  localparam logic [IW-1:0] PTR_LAST  = IW'(NUM_VOICES - 1);

  typedef enum logic {S_IDLE, S_COMMIT} state_t;

  state_t               state;
  logic                 cap_on;
  logic [NOTE_BITS-1:0] cap_num;
  logic [31:0]          cap_vel;
  logic [IW-1:0]        steal_ptr;
  logic [CW-1:0]        tick_cnt;

  logic                  hit_found;
  logic                  free_found;
  logic [IW-1:0]         hit_idx;
  logic [IW-1:0]         free_idx;
  logic [IW-1:0]         tgt_idx;
  logic                  do_steal;
  logic [NUM_VOICES-1:0] off_match;

  // The allocation decision looks only at the registered en/busy state.
  // That way a voice_avail pulse arriving in the commit cycle cannot free
  // a voice in time for the decision made at that same edge.
  always_comb begin
    hit_found  = 1'b0;
    free_found = 1'b0;
    hit_idx    = '0;
    free_idx   = '0;
    off_match  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (voice_en[i] && (voice_note[i*NOTE_BITS +: NOTE_BITS] == cap_num)) begin
        off_match[i] = 1'b1;
        if (!hit_found) begin
          hit_found = 1'b1;
          hit_idx   = IW'(i);
        end
      end
      if (!free_found && !voice_busy[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
    do_steal = !hit_found && !free_found;
    tgt_idx  = hit_found ? hit_idx : (free_found ? free_idx : steal_ptr);
  end

  // The avail clears are written first and the commit writes come after
  // them, so a commit to the same voice in the same cycle overrides them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      note_ready  <= 1'b1;
      cap_on      <= 1'b0;
      cap_num     <= '0;
      cap_vel     <= '0;
      voice_en    <= '0;
      voice_busy  <= '0;
      voice_vel   <= '0;
      voice_note  <= '0;
      voice_steal <= 1'b0;
      steal_ptr   <= '0;
      tick_cnt    <= '0;
      env_tick    <= 1'b0;
    end else begin
      voice_steal <= 1'b0;
      tick_cnt    <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
      // env_tick is registered, so it is raised one count early and is
      // high exactly while tick_cnt holds TICK_DIV-1.
      env_tick    <= (tick_cnt == TICK_PRE);

      for (int i = 0; i < NUM_VOICES; i++) begin
        if (voice_avail[i]) begin
          voice_busy[i] <= 1'b0;
          voice_en[i]   <= 1'b0;
        end
      end

      case (state)
        S_IDLE: begin
          if (note_valid) begin
            cap_on     <= note_on;
            cap_num    <= note_num;
            cap_vel    <= note_vel;
            state      <= S_COMMIT;
            note_ready <= 1'b0;
          end
        end
        S_COMMIT: begin
          state      <= S_IDLE;
          note_ready <= 1'b1;
          if (cap_on) begin
            voice_note[int'(tgt_idx)*NOTE_BITS +: NOTE_BITS] <= cap_num;
            voice_vel[int'(tgt_idx)*32 +: 32]                <= cap_vel;
            voice_en[tgt_idx]                                <= 1'b1;
            voice_busy[tgt_idx]                              <= 1'b1;
            if (do_steal) begin
              voice_steal <= 1'b1;
              steal_ptr   <= (steal_ptr == PTR_LAST) ? '0 : steal_ptr + 1'b1;
            end
          end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (off_match[i]) voice_en[i] <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule
